// File: rtl/nios2_div_pkg.sv
// nios2_div_pkg: shared constants, state encoding and operand helper for the divide cell.
package nios2_div_pkg;
  localparam int DATA_W = 32;
  localparam int ITER_W = 5;
  localparam int DIV_ITERATIONS = 32;
  localparam logic [DATA_W-1:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
    return (s && v[DATA_W-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/nios2_div_step.sv
// nios2_div_step: one combinational radix-2 restoring division iteration.
module nios2_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] sh, diff;
  always_comb begin
    sh = {rem, dvd_bit};
    diff = sh - {1'b0, dvs};
    q_bit = sh >= {1'b0, dvs};
    rem_next = q_bit ? diff[W-1:0] : sh[W-1:0];
  end
endmodule

// File: rtl/nios2_div_cell.sv
// nios2_div_cell: iterative 32-bit signed/unsigned restoring divider, 34 cycles start-to-done.
module nios2_div_cell
  import nios2_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic [DATA_W-1:0] E_src1_div_cell,
  input  logic [DATA_W-1:0] E_src2_div_cell,
  input  logic              A_div_abort,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_quotient,
  output logic [DATA_W-1:0] A_div_remainder
);
  state_t state;
  logic [ITER_W-1:0] cnt;
  logic [DATA_W-1:0] dvd, dvs, rem, rem_nx;
  logic q_bit, neg_q, neg_r, dz;
  nios2_div_step #(.W(DATA_W)) u_step (
    .rem(rem),
    .dvd_bit(dvd[DATA_W-1]),
    .dvs(dvs),
    .rem_next(rem_nx),
    .q_bit(q_bit)
  );
  // dvd doubles as the quotient register: dividend bits shift out the top, quotient bits in the bottom.
  // A zero divisor leaves rem = |src1|, so the signed fixup already restores the original src1 bits.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      A_div_busy <= 1'b0;
      A_div_done <= 1'b0;
      A_div_quotient <= '0;
      A_div_remainder <= '0;
    end else begin
      A_div_done <= 1'b0;
      case (state)
        IDLE: if (E_div_start && !A_div_abort) begin
          state <= CALC;
          cnt <= '0;
          A_div_busy <= 1'b1;
          dvd <= mag(E_src1_div_cell, E_div_signed);
          dvs <= mag(E_src2_div_cell, E_div_signed);
          rem <= '0;
          neg_q <= E_div_signed && (E_src1_div_cell[DATA_W-1] ^ E_src2_div_cell[DATA_W-1]);
          neg_r <= E_div_signed && E_src1_div_cell[DATA_W-1];
          dz <= E_src2_div_cell == '0;
        end
        CALC: if (A_div_abort) begin
          state <= IDLE;
          A_div_busy <= 1'b0;
        end else begin
          rem <= rem_nx;
          dvd <= {dvd[DATA_W-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == ITER_W'(DIV_ITERATIONS - 1)) state <= FIXUP;
        end
        FIXUP: begin
          state <= IDLE;
          A_div_busy <= 1'b0;
          if (!A_div_abort) begin
            A_div_done <= 1'b1;
            A_div_quotient <= dz ? DIV_BY_ZERO_QUOT : (neg_q ? -dvd : dvd);
            A_div_remainder <= neg_r ? -rem : rem;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_nios2_div_cell.sv
// tb_nios2_div_cell: directed checks of latency, sign rules, divide-by-zero, abort and reset.
module tb_nios2_div_cell;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic E_div_start = 1'b0;
  logic E_div_signed = 1'b0;
  logic [31:0] E_src1_div_cell = '0;
  logic [31:0] E_src2_div_cell = '0;
  logic A_div_abort = 1'b0;
  logic A_div_busy, A_div_done;
  logic [31:0] A_div_quotient, A_div_remainder;
  int total = 0;
  int bad = 0;
  int lat, bc, ndone;
  logic [31:0] q_seen, r_seen;

  always #5 clk = ~clk;

  nios2_div_cell dut (
    .clk(clk),
    .reset_n(reset_n),
    .E_div_start(E_div_start),
    .E_div_signed(E_div_signed),
    .E_src1_div_cell(E_src1_div_cell),
    .E_src2_div_cell(E_src2_div_cell),
    .A_div_abort(A_div_abort),
    .A_div_busy(A_div_busy),
    .A_div_done(A_div_done),
    .A_div_quotient(A_div_quotient),
    .A_div_remainder(A_div_remainder)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    E_src1_div_cell = a;
    E_src2_div_cell = b;
    E_div_signed = s;
    E_div_start = 1'b1;
    @(posedge clk);
    #1;
    E_div_start = 1'b0;
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (!A_div_done && l < 60) begin
      if (A_div_busy) b++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] eq, input logic [31:0] er);
    int l, bb;
    start_op(a, b, s);
    wait_done(l, bb);
    chk({tag, "_lat"}, 32'(l), 32'd33);
    chk({tag, "_q"}, A_div_quotient, eq);
    chk({tag, "_r"}, A_div_remainder, er);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, A_div_busy}, 32'd0);
    chk("rst_done", {31'd0, A_div_done}, 32'd0);
    chk("rst_q", A_div_quotient, 32'd0);
    chk("rst_r", A_div_remainder, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    start_op(32'd100, 32'd7, 1'b0);
    wait_done(lat, bc);
    chk("u100_7_lat", 32'(lat), 32'd33);
    chk("u100_7_busy_cycles", 32'(bc), 32'd33);
    chk("u100_7_busy_at_done", {31'd0, A_div_busy}, 32'd0);
    chk("u100_7_q", A_div_quotient, 32'd14);
    chk("u100_7_r", A_div_remainder, 32'd2);
    @(posedge clk);
    #1;
    chk("done_pulse_one_cycle", {31'd0, A_div_done}, 32'd0);

    run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1);
    run("dz_u", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    run("dz_s", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
    run("dz_s_neg", 32'h8765_4321, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321);
    run("ovf_s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run("ovf_u", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);

    start_op(32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    A_div_abort = 1'b1;
    @(posedge clk);
    #1;
    A_div_abort = 1'b0;
    chk("abort_busy_drop", {31'd0, A_div_busy}, 32'd0);
    ndone = 0;
    repeat (40) begin
      if (A_div_done) ndone++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_q_hold", A_div_quotient, 32'd0);
    chk("abort_r_hold", A_div_remainder, 32'h8000_0000);

    start_op(32'd9, 32'd3, 1'b0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    E_src1_div_cell = 32'd100;
    E_src2_div_cell = 32'd7;
    E_div_start = 1'b1;
    @(posedge clk);
    #1;
    E_div_start = 1'b0;
    ndone = 0;
    q_seen = '0;
    r_seen = '0;
    repeat (45) begin
      if (A_div_done) begin
        ndone++;
        q_seen = A_div_quotient;
        r_seen = A_div_remainder;
      end
      @(posedge clk);
      #1;
    end
    chk("busy_start_single_done", 32'(ndone), 32'd1);
    chk("busy_start_q", q_seen, 32'd3);
    chk("busy_start_r", r_seen, 32'd0);

    @(negedge clk);
    E_div_start = 1'b1;
    A_div_abort = 1'b1;
    @(posedge clk);
    #1;
    E_div_start = 1'b0;
    A_div_abort = 1'b0;
    chk("abort_wins_idle", {31'd0, A_div_busy}, 32'd0);

    start_op(32'd1000, 32'd3, 1'b0);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, A_div_busy}, 32'd0);
    chk("midrst_done", {31'd0, A_div_done}, 32'd0);
    chk("midrst_q", A_div_quotient, 32'd0);
    chk("midrst_r", A_div_remainder, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run("u15_4", 32'd15, 32'd4, 1'b0, 32'd3, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
